// File: rtl/tt_uu_paolaunisa_top0_pkg.sv
// rtl/tt_uu_paolaunisa_top0_pkg.sv - shared opcode enumeration and flag bit positions
// Purpose: types and constants shared by the accumulator top and its ALU.
package tt_uu_paolaunisa_top0_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } opcode_e;

  // Flag positions inside uio_out
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 5;
  localparam int FLAG_N = 6;
  localparam int FLAG_V = 7;

endpackage

// File: rtl/tt_uu_paolaunisa_top0_alu.sv
// rtl/tt_uu_paolaunisa_top0_alu.sv - combinational 8-bit ALU for the accumulator
// Purpose: computes next accumulator value plus carry/borrow and signed overflow.
// Ports:
//   acc    in  8  current accumulator
//   b      in  8  operand (ignored for shifts)
//   opcode in  3  operation select
//   result out 8  new accumulator value (mod 256)
//   c      out 1  carry / borrow / shifted-out bit
//   v      out 1  signed overflow (ADD/SUB only)
module paola_alu
  import tt_uu_paolaunisa_top0_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] b,
  input  opcode_e    opcode,
  output logic [7:0] result,
  output logic       c,
  output logic       v
);

  logic [8:0] sum;
  logic [8:0] diff;

  assign sum  = {1'b0, acc} + {1'b0, b};
  // diff[8] is set exactly when acc < b, i.e. the borrow
  assign diff = {1'b0, acc} - {1'b0, b};

  always_comb begin
    result = 8'h00;
    c      = 1'b0;
    v      = 1'b0;
    unique case (opcode)
      OP_LOAD: result = b;
      OP_ADD: begin
        result = sum[7:0];
        c      = sum[8];
        v      = (acc[7] == b[7]) && (sum[7] != acc[7]);
      end
      OP_SUB: begin
        result = diff[7:0];
        c      = diff[8];
        v      = (acc[7] != b[7]) && (diff[7] != acc[7]);
      end
      OP_AND: result = acc & b;
      OP_OR:  result = acc | b;
      OP_XOR: result = acc ^ b;
      OP_SHL: begin
        result = {acc[6:0], 1'b0};
        c      = acc[7];
      end
      OP_SHR: begin
        result = {1'b0, acc[7:1]};
        c      = acc[0];
      end
      default: result = 8'h00;
    endcase
  end

endmodule

// File: rtl/tt_uu_paolaunisa_top0.sv
// rtl/tt_uu_paolaunisa_top0.sv - accumulator with ALU and Z/C/N/V flags
// Purpose: registers ACC and flags, updated on each accepted command.
// Ports:
//   clk     in  1  clock
//   rst_n   in  1  synchronous reset, ACTIVE HIGH despite the name
//   ena     in  1  enable; 0 freezes all state
//   ui_in   in  8  operand B
//   uio_in  in  8  [2:0] opcode, [3] cmd_valid, [7:4] unused
//   uo_out  out 8  accumulator
//   uio_out out 8  [7] V, [6] N, [5] C, [4] Z, [3:0] zero
//   uio_oe  out 8  constant 8'hF0
module tt_uu_paolaunisa_top0
  import tt_uu_paolaunisa_top0_pkg::*;
(
`ifdef GL_TEST
  input  wire        VPWR,
  input  wire        VGND,
`endif
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] acc;
  logic       flag_z, flag_c, flag_n, flag_v;
  logic [7:0] alu_result;
  logic       alu_c, alu_v;
  logic       accept;
  opcode_e    opcode;
  logic       unused_bits;

  assign opcode      = opcode_e'(uio_in[2:0]);
  assign accept      = ena && uio_in[3];
  assign unused_bits = &{1'b0, uio_in[7:4]};

  paola_alu u_alu (
    .acc    (acc),
    .b      (ui_in),
    .opcode (opcode),
    .result (alu_result),
    .c      (alu_c),
    .v      (alu_v)
  );

  // rst_n is active high; it wins over ena and cmd_valid
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc    <= 8'h00;
      flag_z <= 1'b1;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      acc    <= alu_result;
      flag_z <= (alu_result == 8'h00);
      flag_c <= alu_c;
      flag_n <= alu_result[7];
      flag_v <= alu_v;
    end
  end

  always_comb begin
    uio_out         = 8'h00;
    uio_out[FLAG_Z] = flag_z;
    uio_out[FLAG_C] = flag_c;
    uio_out[FLAG_N] = flag_n;
    uio_out[FLAG_V] = flag_v;
  end

  assign uo_out = acc;
  assign uio_oe = 8'hF0;

endmodule

// File: tb/tb_tt_uu_paolaunisa_top0.sv
// tb/tb_tt_uu_paolaunisa_top0.sv - self-checking bench for the accumulator top
module tb_tt_uu_paolaunisa_top0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;

  // reference state as plain integers
  int m_acc = 0;
  int m_z = 1, m_c = 0, m_n = 0, m_v = 0;
  bit m_known = 1'b0;

  tt_uu_paolaunisa_top0 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference model: arithmetic on integers straight from the operation rules
  always @(posedge clk) begin
    int b, op, r, s;
    b  = int'(ui_in);
    op = int'(uio_in[2:0]);
    if (rst_n === 1'b1) begin
      m_acc = 0; m_z = 1; m_c = 0; m_n = 0; m_v = 0;
      m_known = 1'b1;
    end else if (ena === 1'b1 && uio_in[3] === 1'b1) begin
      m_c = 0; m_v = 0;
      case (op)
        0: r = b;
        1: begin
          r = m_acc + b;
          m_c = (r > 255);
          r = r % 256;
          s = to_signed(m_acc) + to_signed(b);
          m_v = (s > 127 || s < -128);
        end
        2: begin
          m_c = (m_acc < b);
          r = (m_acc - b + 256) % 256;
          s = to_signed(m_acc) - to_signed(b);
          m_v = (s > 127 || s < -128);
        end
        3: r = m_acc & b;
        4: r = m_acc | b;
        5: r = m_acc ^ b;
        6: begin m_c = (m_acc >= 128); r = (m_acc * 2) % 256; end
        default: begin m_c = m_acc % 2; r = m_acc / 2; end
      endcase
      m_acc = r;
      m_z = (r == 0);
      m_n = (r >= 128);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("uio_oe", uio_oe, 8'hF0);
    if (m_known) begin
      chk("model_acc", uo_out, 8'(m_acc));
      chk("model_flags", uio_out,
          {m_v[0], m_n[0], m_c[0], m_z[0], 4'h0});
    end
  end

  // One clock per call; inputs change 1 time unit after the falling edge
  task automatic step(input logic r, input logic e, input logic v,
                      input logic [2:0] op, input logic [7:0] b);
    rst_n  = r;
    ena    = e;
    uio_in = {4'h0, v, op};
    ui_in  = b;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] b);
    step(1'b0, 1'b1, 1'b1, op, b);
  endtask

  task automatic pin(input string name, input logic [7:0] acc_exp, input logic [7:0] fl_exp);
    chk({name, "_acc"}, uo_out, acc_exp);
    chk({name, "_flags"}, uio_out, fl_exp);
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    #1;
    // reset for two cycles
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    pin("reset", 8'h00, 8'h10);
    chk("reset_oe", uio_oe, 8'hF0);

    cmd(3'd0, 8'h7F); pin("load7f", 8'h7F, 8'h00);
    cmd(3'd1, 8'h01); pin("add_ovf", 8'h80, 8'hC0);

    cmd(3'd0, 8'hFF); pin("loadff", 8'hFF, 8'h40);
    cmd(3'd1, 8'h01); pin("add_wrap", 8'h00, 8'h30);
    cmd(3'd2, 8'h01); pin("sub_borrow", 8'hFF, 8'h60);

    cmd(3'd0, 8'h81); pin("load81", 8'h81, 8'h40);
    cmd(3'd6, 8'hAA); pin("shl", 8'h02, 8'h20);
    cmd(3'd7, 8'h55); pin("shr", 8'h01, 8'h00);
    cmd(3'd5, 8'hFF); pin("xor", 8'hFE, 8'h40);

    step(1'b0, 1'b0, 1'b1, 3'd1, 8'h05); pin("ena_low", 8'hFE, 8'h40);
    step(1'b0, 1'b1, 1'b0, 3'd1, 8'h05); pin("valid_low", 8'hFE, 8'h40);

    cmd(3'd0, 8'h80); cmd(3'd2, 8'h01); pin("sub_ovf", 8'h7F, 8'h80);
    cmd(3'd0, 8'h80); cmd(3'd1, 8'h80); pin("add_80_80", 8'h00, 8'hB0);
    cmd(3'd0, 8'hF0); cmd(3'd3, 8'h3C); pin("and", 8'h30, 8'h00);
    cmd(3'd4, 8'h81); pin("or", 8'hB1, 8'h40);
    cmd(3'd7, 8'h00); pin("shr_c", 8'h58, 8'h20);
    cmd(3'd2, 8'h58); pin("sub_zero", 8'h00, 8'h10);

    // reset with a command in the same cycle
    step(1'b1, 1'b1, 1'b1, 3'd1, 8'h10); pin("rst_cmd", 8'h00, 8'h10);
    cmd(3'd0, 8'h3C); pin("after_rst", 8'h3C, 8'h00);

    // back-to-back mix checked only by the model
    for (int i = 0; i < 24; i++) begin
      cmd(3'(i % 8), 8'(i * 37 + 11));
    end
    step(1'b0, 1'b0, 1'b1, 3'd1, 8'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
